// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Transmit-side byte FIFO between the UART MMIO register block
//             and the uart_tx serializer. A drain FSM pops one byte at a
//             time, pulses the serializer start input, and tracks the
//             busy handshake. The module exports level, full, empty,
//             sticky overflow and idle status.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int DEPTH         = 16,
   parameter int ADDR_W        = 4,
   parameter int START_TIMEOUT = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_en,
   input  logic [7:0]        i_wr_data,
   input  logic              i_flush,
   input  logic              i_ovf_clr,
   output logic              o_full,
   output logic              o_empty,
   output logic [ADDR_W:0]   o_level,
   output logic              o_overflow,
   output logic              o_idle,
   output logic [7:0]        o_tx_data,
   output logic              o_tx_start,
   input  logic              i_tx_busy
);

   // Counter wide enough to hold START_TIMEOUT itself.
   localparam int CNT_W_RAW = $clog2(START_TIMEOUT + 1);
   localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

   localparam logic [ADDR_W:0]   FULL_LEVEL   = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   LEVEL_ONE    = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE      = ADDR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(START_TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Storage and bookkeeping state
   // ------------------------------------------------------------------------
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   level;
   logic              overflow;
   logic [7:0]        tx_data;

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  tmo_cnt;
   logic [CNT_W-1:0]  tmo_cnt_inc;

   // Control decoded from the FSM
   logic              pop;
   logic              tmo_clr;
   logic              tmo_inc;
   logic              tx_start;

   // Push qualification. A full FIFO never accepts, even when a pop retires
   // an entry in the same cycle; a push coinciding with flush is silently
   // discarded and is not counted as an overflow.
   logic              push_ok;
   logic              drop;

   assign push_ok     = i_wr_en && !o_full && !i_flush;
   assign drop        = i_wr_en &&  o_full && !i_flush;
   assign tmo_cnt_inc = tmo_cnt + CNT_ONE;

   // ------------------------------------------------------------------------
   // Status outputs, all derived from registered state
   // ------------------------------------------------------------------------
   assign o_level    = level;
   assign o_full     = (level == FULL_LEVEL);
   assign o_empty    = (level == '0);
   assign o_overflow = overflow;
   assign o_idle     = o_empty && (state == ST_IDLE);
   assign o_tx_data  = tx_data;
   assign o_tx_start = tx_start;

   // Byte storage; no reset needed since occupancy is tracked by level.
   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= i_wr_data;
      end
   end

   // Write pointer: advances on accepted pushes, returns to zero on flush.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         wr_ptr <= '0;
      end else if (push_ok) begin
         wr_ptr <= wr_ptr + PTR_ONE;
      end
   end

   // Read pointer: advances on each pop, returns to zero on flush.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         rd_ptr <= '0;
      end else if (pop) begin
         rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Occupancy counter; simultaneous push and pop leave it unchanged.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         level <= '0;
      end else begin
         case ({push_ok, pop})
            2'b10:   level <= level + LEVEL_ONE;
            2'b01:   level <= level - LEVEL_ONE;
            default: level <= level;
         endcase
      end
   end

   // Sticky overflow flag; a dropped push beats a clear in the same cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (i_ovf_clr) begin
         overflow <= 1'b0;
      end
   end

   // Serializer data register: captured at pop, held until the next pop.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tx_data <= 8'h00;
      end else if (pop) begin
         tx_data <= mem[rd_ptr];
      end
   end

   // Start-handshake timeout counter, cleared in LOAD.
   always_ff @(posedge i_clk) begin
      if (i_rst || tmo_clr) begin
         tmo_cnt <= '0;
      end else if (tmo_inc) begin
         tmo_cnt <= tmo_cnt_inc;
      end
   end

   // ------------------------------------------------------------------------
   // Drain FSM
   // ------------------------------------------------------------------------

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and control decode.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      tmo_clr    = 1'b0;
      tmo_inc    = 1'b0;
      tx_start   = 1'b0;

      case (state)
         ST_IDLE: begin
            // Only launch when the serializer has finished its last frame.
            if (!o_empty && !i_tx_busy) begin
               pop        = 1'b1;
               state_next = ST_LOAD;
            end
         end

         ST_LOAD: begin
            tx_start   = 1'b1;
            tmo_clr    = 1'b1;
            state_next = ST_WAIT_BUSY;
         end

         ST_WAIT_BUSY: begin
            if (i_tx_busy) begin
               state_next = ST_WAIT_DONE;
            end else begin
               // Serializer never acknowledged: give up, the byte is lost.
               tmo_inc = 1'b1;
               if (tmo_cnt_inc == TIMEOUT_LAST) begin
                  state_next = ST_IDLE;
               end
            end
         end

         ST_WAIT_DONE: begin
            if (!i_tx_busy) begin
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Directed self-checking bench for uart_tx_fifo with a small
//             serializer model (configurable busy length, stall, no-ack).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk;
   logic              rst;
   logic              wr_en;
   logic [7:0]        wr_data;
   logic              flush;
   logic              ovf_clr;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   level;
   logic              overflow;
   logic              idle;
   logic [7:0]        tx_data;
   logic              tx_start;
   logic              tx_busy;

   // Serializer model controls
   logic              hold_busy;
   logic              never_busy;
   int                busy_len;
   int                ser_cnt;

   // Observation
   logic [7:0]        sent [$];
   int                start_count;
   int                max_level;

   int                checks;
   int                errors;

   uart_tx_fifo #(
      .DEPTH        (DEPTH),
      .ADDR_W       (ADDR_W),
      .START_TIMEOUT(4)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_wr_en    (wr_en),
      .i_wr_data  (wr_data),
      .i_flush    (flush),
      .i_ovf_clr  (ovf_clr),
      .o_full     (full),
      .o_empty    (empty),
      .o_level    (level),
      .o_overflow (overflow),
      .o_idle     (idle),
      .o_tx_data  (tx_data),
      .o_tx_start (tx_start),
      .i_tx_busy  (tx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign tx_busy = hold_busy | (ser_cnt != 0);

   // Serializer model: busy rises the cycle after start and lasts busy_len.
   always @(posedge clk) begin
      if (rst) begin
         ser_cnt <= 0;
      end else if (tx_start && !never_busy) begin
         ser_cnt <= busy_len;
      end else if (ser_cnt != 0) begin
         ser_cnt <= ser_cnt - 1;
      end
   end

   // Record every byte launched toward the serializer.
   always @(posedge clk) begin
      if (!rst && tx_start) begin
         sent.push_back(tx_data);
         start_count <= start_count + 1;
      end
   end

   // Track peak occupancy.
   always @(negedge clk) begin
      if (int'(level) > max_level) max_level <= int'(level);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n;
      n = 0;
      while (!idle && n < limit) begin
         tick();
         n++;
      end
      check(tag, {31'd0, idle}, 32'd1);
   endtask

   task automatic wait_sent(input string tag, input int target, input int limit);
      int n;
      n = 0;
      while (sent.size() < target && n < limit) begin
         tick();
         n++;
      end
      check(tag, sent.size(), target);
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_level"},    {27'd0, level},    32'd0);
      check({pfx, "_empty"},    {31'd0, empty},    32'd1);
      check({pfx, "_full"},     {31'd0, full},     32'd0);
      check({pfx, "_overflow"}, {31'd0, overflow}, 32'd0);
      check({pfx, "_start"},    {31'd0, tx_start}, 32'd0);
      check({pfx, "_data"},     {24'd0, tx_data},  32'd0);
      check({pfx, "_idle"},     {31'd0, idle},     32'd1);
   endtask

   // Watchdog: the bench must never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int sc;
      logic any_start;

      checks      = 0;
      errors      = 0;
      start_count = 0;
      max_level   = 0;
      rst         = 1'b1;
      wr_en       = 1'b0;
      wr_data     = 8'h00;
      flush       = 1'b0;
      ovf_clr     = 1'b0;
      hold_busy   = 1'b0;
      never_busy  = 1'b0;
      busy_len    = 10;

      repeat (3) tick();
      rst = 1'b0;
      check_reset_values("rst");

      // ---------------- single byte ----------------
      base = sent.size();
      wr_en = 1'b1; wr_data = 8'hA5;
      tick();                                          // cycle 1
      check("single_level1", {27'd0, level}, 32'd1);
      check("single_start_c1", {31'd0, tx_start}, 32'd0);
      wr_en = 1'b0;
      tick();                                          // cycle 2
      check("single_start_c2", {31'd0, tx_start}, 32'd1);
      check("single_data", {24'd0, tx_data}, 32'hA5);
      check("single_level0", {27'd0, level}, 32'd0);
      tick();                                          // cycle 3
      check("single_start_c3", {31'd0, tx_start}, 32'd0);
      repeat (10) tick();                              // cycle 13
      check("single_idle_c13", {31'd0, idle}, 32'd0);
      tick();                                          // cycle 14
      check("single_idle_c14", {31'd0, idle}, 32'd1);
      check("single_count", sent.size() - base, 32'd1);
      check("single_hold", {24'd0, tx_data}, 32'hA5);

      // ---------------- fill and overflow ----------------
      base = sent.size();
      hold_busy = 1'b1;
      for (int i = 0; i < 17; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         tick();
      end
      wr_en = 1'b0;
      check("fill_full", {31'd0, full}, 32'd1);
      check("fill_level", {27'd0, level}, 32'd16);
      check("fill_overflow", {31'd0, overflow}, 32'd1);
      check("fill_no_start", sent.size() - base, 32'd0);
      hold_busy = 1'b0;
      wait_sent("fill_drain", base + 16, 400);
      wait_idle("fill_idle", 40);
      repeat (5) tick();
      check("fill_count", sent.size() - base, 32'd16);
      for (int i = 0; i < 16; i++) begin
         if (base + i < sent.size())
            check($sformatf("fill_byte%0d", i), {24'd0, sent[base + i]}, 32'(i));
      end
      check("ovf_sticky", {31'd0, overflow}, 32'd1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("ovf_cleared", {31'd0, overflow}, 32'd0);

      // ---------------- wrap and simultaneity ----------------
      base = sent.size();
      busy_len = 2;
      for (int k = 0; k < 40; k++) begin
         wr_en = 1'b1; wr_data = 8'h30 + 8'(k);
         tick();
         wr_en = 1'b0;
         repeat (3) tick();
      end
      wait_sent("wrap_drain", base + 40, 400);
      wait_idle("wrap_idle", 40);
      for (int k = 0; k < 40; k++) begin
         if (base + k < sent.size())
            check($sformatf("wrap_byte%0d", k), {24'd0, sent[base + k]}, 32'h30 + 32'(k));
      end
      check("wrap_no_ovf", {31'd0, overflow}, 32'd0);
      check("wrap_max_level_ok", {31'd0, (max_level <= DEPTH)}, 32'd1);

      // ---------------- flush ----------------
      base = sent.size();
      busy_len = 10;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = 8'h11 + 8'(i);
         tick();
      end
      check("flush_level_before", {27'd0, level}, 32'd4);
      flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
      tick();
      flush = 1'b0; wr_en = 1'b0;
      check("flush_level", {27'd0, level}, 32'd0);
      check("flush_empty", {31'd0, empty}, 32'd1);
      check("flush_no_ovf", {31'd0, overflow}, 32'd0);
      check("flush_inflight", {31'd0, idle}, 32'd0);
      wait_idle("flush_idle", 40);
      repeat (5) tick();
      check("flush_count", sent.size() - base, 32'd1);
      if (sent.size() > base)
         check("flush_byte", {24'd0, sent[base]}, 32'h11);

      // ---------------- start timeout ----------------
      base = sent.size();
      never_busy = 1'b1;
      wr_en = 1'b1; wr_data = 8'h21;
      tick();                                          // cycle 1
      wr_data = 8'h22;
      tick();                                          // cycle 2
      wr_en = 1'b0;
      check("tmo_start1", {31'd0, tx_start}, 32'd1);
      check("tmo_data1", {24'd0, tx_data}, 32'h21);
      check("tmo_level_c2", {27'd0, level}, 32'd1);
      any_start = 1'b0;
      for (int c = 3; c <= 7; c++) begin
         tick();
         any_start = any_start | tx_start;
      end
      check("tmo_quiet", {31'd0, any_start}, 32'd0);
      tick();                                          // cycle 8
      check("tmo_start2", {31'd0, tx_start}, 32'd1);
      check("tmo_data2", {24'd0, tx_data}, 32'h22);
      check("tmo_level_c8", {27'd0, level}, 32'd0);
      repeat (4) tick();                               // cycle 12
      check("tmo_idle_c12", {31'd0, idle}, 32'd0);
      tick();                                          // cycle 13
      check("tmo_idle_c13", {31'd0, idle}, 32'd1);
      check("tmo_count", sent.size() - base, 32'd2);
      never_busy = 1'b0;

      // ---------------- reset mid-operation ----------------
      busy_len = 10;
      for (int i = 0; i < 7; i++) begin
         wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
         tick();
      end
      wr_en = 1'b0;
      check("midrst_level", {27'd0, level}, 32'd6);
      check("midrst_busy", {31'd0, tx_busy}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_values("midrst");
      sc = start_count;
      repeat (20) tick();
      check("midrst_no_start", start_count, sc);
      check("midrst_still_idle", {31'd0, idle}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit-side buffer stage between the UART MMIO register block and the uart_tx serializer. Software writes bytes into a DEPTH-entry FIFO at bus speed. A drain FSM pops bytes one at a time, pulses the serializer start input, and waits for the serializer's busy handshake to complete. Level, full, empty and sticky overflow status are exported for MMIO readback and interrupt generation.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
ADDR_W, 4, log2(DEPTH); pointer width
START_TIMEOUT, 4, cycles to wait for i_tx_busy to rise after a start pulse before abandoning the handshake

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_wr_en  in  1  push strobe from MMIO, one byte per cycle high
i_wr_data  in  8  byte to push
i_flush  in  1  discard all queued (not in-flight) bytes
i_ovf_clr  in  1  clear sticky overflow flag
o_full  out  1  level == DEPTH
o_empty  out  1  level == 0
o_level  out  ADDR_W+1  current occupancy, 0..DEPTH
o_overflow  out  1  sticky: a push was dropped
o_idle  out  1  FIFO empty and drain FSM in IDLE (TX-empty interrupt source)
o_tx_data  out  8  byte presented to serializer
o_tx_start  out  1  one-cycle start pulse to serializer
i_tx_busy  in  1  serializer busy

Behaviour:
- Reset values: pointers 0; o_level 0; o_empty 1; o_full 0; o_overflow 0; o_tx_start 0; o_tx_data 8'h00; o_idle 1; FSM IDLE. Reset mid-frame drops the queue and the in-flight handshake. The serializer is reset by the same i_rst.
- Storage: DEPTH x 8 register array. Write and read pointers are ADDR_W bits and wrap modulo DEPTH. Level is tracked as a separate ADDR_W+1 counter. All status outputs are registered or derived from registered state only.
- Push: on i_wr_en with !o_full, write at wr_ptr; wr_ptr+1; level+1.
- Push while o_full: byte dropped, o_overflow set next cycle. This applies even if a pop happens the same cycle; a full FIFO never accepts.
- Pop: occurs only in the FSM IDLE->LOAD transition; rd_ptr+1; level-1.
- Push and pop in the same cycle: level unchanged, both pointers advance.
- Flush: next cycle rd_ptr=wr_ptr=0 and level=0. A push in the same cycle as i_flush is discarded without setting overflow. Flush does not abort the FSM: an in-flight byte completes normally.
- i_ovf_clr clears o_overflow. If a dropped push happens in the same cycle, set wins.
- FSM states:
  - IDLE: if !o_empty && !i_tx_busy, latch mem[rd_ptr] into o_tx_data, pop, go to LOAD.
  - LOAD: o_tx_start=1 for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY: if i_tx_busy, go to WAIT_DONE. Otherwise increment the counter; when it reaches START_TIMEOUT, go to IDLE. The byte is lost on timeout; no retry.
  - WAIT_DONE: when !i_tx_busy, go to IDLE.
- Latency: push in cycle 0 into an empty FIFO with the serializer idle: level=1 in cycle 1, o_tx_start high in cycle 2.
- Back-to-back throughput: busy falling in cycle N gives IDLE in N+1 and the next start in N+2.
- o_tx_data holds its value from LOAD until the next IDLE->LOAD transition.
- o_idle = o_empty && state==IDLE.

Test Plan:
- Single byte: push 8'hA5 in cycle 0, serializer model raises busy 1 cycle after start and holds it 10 cycles -> o_tx_start single pulse in cycle 2, o_tx_data=A5, o_level 1->0, o_idle=1 after busy falls.
- Fill and overflow: hold busy=1, push 0x00..0x10 (17 bytes) -> o_full after 16, o_level=16, o_overflow=1; release busy -> bytes 0x00..0x0F emerge in order, 0x10 never appears; i_ovf_clr -> overflow 0.
- Wrap and simultaneity: stream 40 bytes with pushes coinciding with pops -> output order matches input, level never exceeds 16, pointers wrap cleanly.
- Flush: queue 5 bytes with the first in flight, assert i_flush plus a push of 8'h77 -> in-flight byte completes, level=0, 0x77 not sent, overflow 0.
- Timeout: serializer model never asserts busy -> FSM returns to IDLE 4 cycles after WAIT_BUSY entry, next byte starts, one byte lost.
- Reset mid-operation: assert i_rst with 6 bytes queued during WAIT_DONE -> all outputs at reset values next cycle, no further o_tx_start.
